// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the LC-3 control unit / SRAM pads and mem_access_ctrl.
// Signals:
//   Mem_CE/Mem_OE/Mem_WE  active-low request strobes from the control unit
//   ADDR, Data_from_CPU   MAR / MDR contents
//   Data_from_SRAM        SRAM data bus, pad input side
//   Switches              board switches returned on I/O reads
//   Data_to_CPU           registered read data toward MDR
//   Data_to_SRAM, Data_oe write data toward the pad and its tristate enable
//   SRAM_ADDR, SRAM_*_N   SRAM address and active-low strobes
//   HEX_Data              memory-mapped hex display register
//   Busy, Done            controller status
// Modports: slave = the controller, master = control unit plus SRAM side.
interface mem_access_ctrl_if;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic [15:0] Data_to_SRAM;
  logic        Data_oe;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [15:0] HEX_Data;
  logic        Busy;
  logic        Done;

  modport slave (
    input  Mem_CE, Mem_OE, Mem_WE, ADDR, Data_from_CPU, Data_from_SRAM, Switches,
    output Data_to_CPU, Data_to_SRAM, Data_oe, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
           SRAM_WE_N, HEX_Data, Busy, Done
  );

  modport master (
    output Mem_CE, Mem_OE, Mem_WE, ADDR, Data_from_CPU, Data_from_SRAM, Switches,
    input  Data_to_CPU, Data_to_SRAM, Data_oe, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
           SRAM_WE_N, HEX_Data, Busy, Done
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller between the LC-3 control unit and an asynchronous
// 16-bit SRAM. Each strobe assertion becomes exactly one timed SRAM read or
// write with WAIT_STATES extra pulse cycles; one address (IO_ADDR) is decoded
// as memory-mapped I/O (reads return Switches, writes load HEX_Data).
// Ports:
//   Clk    system clock, all state changes on the rising edge
//   Reset  synchronous, active-high reset
//   bus    mem_access_ctrl_if.slave, all outputs registered
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mem_access_ctrl_if.slave      bus
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  typedef enum logic [3:0] {
    IDLE,
    RD_PULSE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    IO_RD,
    IO_WR,
    DONE,
    RELEASE
  } state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [15:0] io_wr_data;

  // Outputs are set on the edge that enters a state, so every strobe is
  // already valid for the whole first cycle of that state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= IDLE;
      wait_cnt         <= 3'd0;
      io_wr_data       <= 16'h0000;
      bus.Data_to_CPU  <= 16'h0000;
      bus.Data_to_SRAM <= 16'h0000;
      bus.Data_oe      <= 1'b0;
      bus.SRAM_ADDR    <= 20'h00000;
      bus.SRAM_CE_N    <= 1'b1;
      bus.SRAM_OE_N    <= 1'b1;
      bus.SRAM_WE_N    <= 1'b1;
      bus.HEX_Data     <= 16'h0000;
      bus.Busy         <= 1'b0;
      bus.Done         <= 1'b0;
    end else begin
      // Done is a single-cycle pulse; only the states that enter DONE raise it.
      bus.Done <= 1'b0;

      case (state)
        IDLE: begin
          // Write wins when both OE and WE are low.
          if (!bus.Mem_CE && !bus.Mem_WE) begin
            bus.Busy <= 1'b1;
            if (bus.ADDR == IO_ADDR) begin
              io_wr_data <= bus.Data_from_CPU;
              state      <= IO_WR;
            end else begin
              bus.SRAM_ADDR    <= {4'h0, bus.ADDR};
              bus.Data_to_SRAM <= bus.Data_from_CPU;
              bus.SRAM_CE_N    <= 1'b0;
              bus.Data_oe      <= 1'b1;
              state            <= WR_SETUP;
            end
          end else if (!bus.Mem_CE && !bus.Mem_OE) begin
            bus.Busy <= 1'b1;
            if (bus.ADDR == IO_ADDR) begin
              state <= IO_RD;
            end else begin
              bus.SRAM_ADDR <= {4'h0, bus.ADDR};
              bus.SRAM_CE_N <= 1'b0;
              bus.SRAM_OE_N <= 1'b0;
              wait_cnt      <= WAIT_LOAD;
              state         <= RD_PULSE;
            end
          end
        end

        RD_PULSE: begin
          if (wait_cnt == 3'd0) begin
            // Last strobe cycle: SRAM data has had the full pulse to settle.
            bus.Data_to_CPU <= bus.Data_from_SRAM;
            bus.SRAM_CE_N   <= 1'b1;
            bus.SRAM_OE_N   <= 1'b1;
            bus.Done        <= 1'b1;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        WR_SETUP: begin
          bus.SRAM_WE_N <= 1'b0;
          wait_cnt      <= WAIT_LOAD;
          state         <= WR_PULSE;
        end

        WR_PULSE: begin
          if (wait_cnt == 3'd0) begin
            // WE rises one cycle before the data bus is released (hold time).
            bus.SRAM_WE_N <= 1'b1;
            state         <= WR_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        WR_HOLD: begin
          bus.SRAM_CE_N <= 1'b1;
          bus.Data_oe   <= 1'b0;
          bus.Done      <= 1'b1;
          state         <= DONE;
        end

        IO_RD: begin
          bus.Data_to_CPU <= bus.Switches;
          bus.Done        <= 1'b1;
          state           <= DONE;
        end

        IO_WR: begin
          bus.HEX_Data <= io_wr_data;
          bus.Done     <= 1'b1;
          state        <= DONE;
        end

        DONE: begin
          state <= RELEASE;
        end

        RELEASE: begin
          // A strobe still held low from this access must not start another.
          if (bus.Mem_OE && bus.Mem_WE) begin
            bus.Busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          bus.SRAM_CE_N <= 1'b1;
          bus.SRAM_OE_N <= 1'b1;
          bus.SRAM_WE_N <= 1'b1;
          bus.Data_oe   <= 1'b0;
          bus.Busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl. A driver issues CPU
// requests and pushes the expected outcome; a monitor pops and compares on
// every Done pulse. An SRAM model serves reads and commits writes on the
// rising edge of SRAM_WE_N.
module tb_mem_access_ctrl;

  localparam int          WS = 1;
  localparam logic [15:0] IO = 16'hFFFF;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.WAIT_STATES(WS), .IO_ADDR(IO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef enum {K_RD, K_WR, K_IORD, K_IOWR} kind_e;

  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    logic [15:0] data;   // read result, or written value
    logic [15:0] dcpu;   // Data_to_CPU expected after completion
    logic [15:0] hex;    // HEX_Data expected after completion
    int          issue;  // cycle count when the request was applied
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] ref_dcpu = 16'h0000;
  logic [15:0] ref_hex  = 16'h0000;

  always @(posedge Clk) cyc <= cyc + 1;

  // Power-up contents shared by the SRAM model and the reference memory.
  function automatic logic [15:0] init_val(logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] sram_rd(logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a[15:0]);
  endfunction

  function automatic logic [15:0] ref_rd(logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic prev_we_n = 1'b1;
  always @(negedge Clk) begin
    if (bus.SRAM_CE_N === 1'b0 && bus.SRAM_OE_N === 1'b0)
      bus.Data_from_SRAM = sram_rd(bus.SRAM_ADDR);
    else
      bus.Data_from_SRAM = 16'hDEAD;
    if (prev_we_n === 1'b0 && bus.SRAM_WE_N === 1'b1 && bus.Data_oe === 1'b1)
      sram_mem[bus.SRAM_ADDR] = bus.Data_to_SRAM;
    prev_we_n = bus.SRAM_WE_N;
  end

  // ---------------- Monitor / scoreboard ----------------
  int   ce_cnt, oe_cnt, we_cnt, doe_cnt;
  bit   addr_bad;
  exp_t e;
  int   lat_e, ce_e, oe_e, we_e, doe_e;

  always @(negedge Clk) begin
    if (bus.Data_oe === 1'b1)
      check("no_contention", 32'(bus.SRAM_OE_N), 32'd1);

    if (bus.Busy === 1'b0) begin
      check("idle_strobes",
            32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.Data_oe}), 32'hE);
      ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; addr_bad = 1'b0;
    end else if (bus.Busy === 1'b1) begin
      if (bus.SRAM_CE_N === 1'b0) ce_cnt++;
      if (bus.SRAM_OE_N === 1'b0) oe_cnt++;
      if (bus.SRAM_WE_N === 1'b0) we_cnt++;
      if (bus.Data_oe   === 1'b1) doe_cnt++;
      if (bus.SRAM_CE_N === 1'b0 && exp_q.size() > 0 &&
          bus.SRAM_ADDR !== {4'h0, exp_q[0].addr})
        addr_bad = 1'b1;
    end

    if (bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got Done=1 required no pending transaction");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_RD:    begin lat_e = WS + 2; ce_e = WS + 1; oe_e = WS + 1; we_e = 0;      doe_e = 0;      end
          K_WR:    begin lat_e = WS + 4; ce_e = WS + 3; oe_e = 0;      we_e = WS + 1; doe_e = WS + 3; end
          default: begin lat_e = 2;      ce_e = 0;      oe_e = 0;      we_e = 0;      doe_e = 0;      end
        endcase
        check("latency",      32'(cyc - e.issue), 32'(lat_e));
        check("ce_cycles",    32'(ce_cnt),  32'(ce_e));
        check("oe_cycles",    32'(oe_cnt),  32'(oe_e));
        check("we_cycles",    32'(we_cnt),  32'(we_e));
        check("data_oe_cycles", 32'(doe_cnt), 32'(doe_e));
        check("sram_addr_ok", 32'(addr_bad), 32'd0);
        if (e.kind == K_RD || e.kind == K_IORD)
          check("read_data", 32'(bus.Data_to_CPU), 32'(e.data));
        else
          check("cpu_data_held", 32'(bus.Data_to_CPU), 32'(e.dcpu));
        if (e.kind == K_WR)
          check("sram_write_data", 32'(sram_rd({4'h0, e.addr})), 32'(e.data));
        check("hex_data", 32'(bus.HEX_Data), 32'(e.hex));
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; addr_bad = 1'b0;
      end
    end
  end

  // ---------------- Driver ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (bus.Busy !== 1'b0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (bus.Busy !== 1'b0) check("idle_timeout", 32'(bus.Busy), 32'd0);
  endtask

  task automatic txn(bit rd, bit wr, logic [15:0] addr, logic [15:0] wdata,
                     logic [15:0] sw, int hold);
    exp_t x;
    int   n = 0;
    wait_idle();
    bus.Switches      = sw;
    bus.ADDR          = addr;
    bus.Data_from_CPU = wdata;
    bus.Mem_CE        = 1'b0;
    bus.Mem_OE        = !rd;
    bus.Mem_WE        = !wr;

    x.addr  = addr;
    x.issue = cyc;
    if (wr) begin
      x.data = wdata;
      if (addr == IO) begin x.kind = K_IOWR; ref_hex = wdata; end
      else begin x.kind = K_WR; ref_mem[addr] = wdata; end
    end else if (addr == IO) begin
      x.kind = K_IORD; x.data = sw; ref_dcpu = sw;
    end else begin
      x.kind = K_RD; x.data = ref_rd(addr); ref_dcpu = x.data;
    end
    x.dcpu = ref_dcpu;
    x.hex  = ref_hex;
    exp_q.push_back(x);

    // Once latched, the address and write data must no longer matter.
    do begin
      @(negedge Clk);
      n++;
      if (bus.Busy === 1'b1) begin
        bus.ADDR          = 16'($urandom);
        bus.Data_from_CPU = 16'($urandom);
      end
    end while (bus.Done !== 1'b1 && n < 30);
    if (bus.Done !== 1'b1) check("done_timeout", 32'(bus.Done), 32'd1);

    repeat (hold) @(negedge Clk);
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b1;
    bus.Mem_CE = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.ADDR = 16'h0; bus.Data_from_CPU = 16'h0; bus.Switches = 16'h0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_busy",      32'(bus.Busy),        32'd0);
    check("rst_done",      32'(bus.Done),        32'd0);
    check("rst_ce_n",      32'(bus.SRAM_CE_N),   32'd1);
    check("rst_oe_n",      32'(bus.SRAM_OE_N),   32'd1);
    check("rst_we_n",      32'(bus.SRAM_WE_N),   32'd1);
    check("rst_data_oe",   32'(bus.Data_oe),     32'd0);
    check("rst_dcpu",      32'(bus.Data_to_CPU), 32'd0);
    check("rst_hex",       32'(bus.HEX_Data),    32'd0);
    check("rst_sram_addr", 32'(bus.SRAM_ADDR),   32'd0);
    Reset = 1'b0;

    // Directed cases
    txn(1, 0, 16'h0010, 16'h0000, 16'h0000, 0);   // SRAM returns BEEF
    txn(0, 1, 16'h0020, 16'h1234, 16'h0000, 0);
    txn(1, 0, 16'h0020, 16'h0000, 16'h0000, 1);
    txn(1, 0, IO,       16'h0000, 16'h00A5, 0);
    txn(0, 1, IO,       16'h0042, 16'h0000, 2);
    txn(1, 0, 16'h0010, 16'h0000, 16'h0000, 10);  // OE held: one access only
    txn(1, 1, 16'h0030, 16'hC0DE, 16'h0000, 0);   // write wins, no OE pulse
    txn(1, 0, 16'h0030, 16'h0000, 16'h0000, 0);

    // Requests with Mem_CE high are ignored
    wait_idle();
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0; bus.ADDR = 16'h0030;
    repeat (4) begin
      @(negedge Clk);
      check("ce_high_no_busy", 32'(bus.Busy), 32'd0);
    end
    bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int          r;
      logic [15:0] a;
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 4) == 0) ? IO : 16'($urandom_range(0, 15));
      txn(r <= 3 || r >= 8, r >= 4, a, 16'($urandom), 16'($urandom),
          int'($urandom_range(0, 4)));
    end

    // Reset during the first write-pulse cycle abandons the write
    wait_idle();
    bus.ADDR = 16'h0050; bus.Data_from_CPU = 16'hAAAA;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0; bus.Mem_OE = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (bus.SRAM_WE_N !== 1'b0 && n < 10);
    check("we_pulse_seen", 32'(bus.SRAM_WE_N), 32'd0);
    Reset = 1'b1;
    bus.Mem_CE = 1'b1; bus.Mem_WE = 1'b1;
    @(negedge Clk);
    check("abort_we_n",    32'(bus.SRAM_WE_N),   32'd1);
    check("abort_ce_n",    32'(bus.SRAM_CE_N),   32'd1);
    check("abort_data_oe", 32'(bus.Data_oe),     32'd0);
    check("abort_hex",     32'(bus.HEX_Data),    32'd0);
    check("abort_busy",    32'(bus.Busy),        32'd0);
    check("abort_dcpu",    32'(bus.Data_to_CPU), 32'd0);
    check("abort_done",    32'(bus.Done),        32'd0);
    Reset = 1'b0;
    ref_dcpu = 16'h0000;
    ref_hex  = 16'h0000;

    // Abandoned write left the location untouched
    txn(1, 0, 16'h0050, 16'h0000, 16'h0000, 0);

    wait_idle();
    repeat (3) @(negedge Clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
